// File: rtl/mult_div_unit_if.sv
// Execute-stage side of the multiply/divide unit: request strobe, opcode, operands,
// MFHI/MFLO read data and the busy/done/div-by-zero status.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             w_start;
    logic [5:0]       w_op_code_6;
    logic [WIDTH-1:0] w_input1_x;
    logic [WIDTH-1:0] w_input2_x;
    logic [WIDTH-1:0] w_output_x;
    logic             w_busy;
    logic             w_done;
    logic             w_div_by_zero;

    modport master (
        output w_start, w_op_code_6, w_input1_x, w_input2_x,
        input  w_output_x, w_busy, w_done, w_div_by_zero
    );

    modport slave (
        input  w_start, w_op_code_6, w_input1_x, w_input2_x,
        output w_output_x, w_busy, w_done, w_div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier and restoring divider with architectural HI/LO,
// one result bit per cycle, sign handled by magnitude conversion and a final fix-up.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

    state_t state, next_state;

    logic [WIDTH-1:0]   hi, lo;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   operand;
    logic [CNT_W-1:0]   count;
    logic               div_op, res_neg, rem_neg;
    logic               dbz_pending;
    logic [WIDTH-1:0]   dbz_value;
    logic               done, div_by_zero;

    logic               is_mul, is_div, is_signed, divisor_zero;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;

    logic               accept_mul, accept_div, accept_dbz;
    logic               write_hi, write_lo, done_next;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_fits;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient, remainder;

    // The magnitude of the most-negative operand wraps to 2^(WIDTH-1), which is
    // still correct when read as unsigned.
    always_comb begin
        is_mul       = (bus.w_op_code_6 == OP_MULT) || (bus.w_op_code_6 == OP_MULTU);
        is_div       = (bus.w_op_code_6 == OP_DIV)  || (bus.w_op_code_6 == OP_DIVU);
        is_signed    = (bus.w_op_code_6 == OP_MULT) || (bus.w_op_code_6 == OP_DIV);
        sign_a       = is_signed & bus.w_input1_x[WIDTH-1];
        sign_b       = is_signed & bus.w_input2_x[WIDTH-1];
        mag_a        = sign_a ? -bus.w_input1_x : bus.w_input1_x;
        mag_b        = sign_b ? -bus.w_input2_x : bus.w_input2_x;
        divisor_zero = (bus.w_input2_x == '0);
    end

    // A pending divide-by-zero write blocks new requests so it cannot collide with an MT write.
    always_comb begin
        next_state = state;
        accept_mul = 1'b0;
        accept_div = 1'b0;
        accept_dbz = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.w_start && !dbz_pending) begin
                    if (is_mul) begin
                        accept_mul = 1'b1;
                        next_state = MUL;
                    end else if (is_div && divisor_zero) begin
                        accept_dbz = 1'b1;
                    end else if (is_div) begin
                        accept_div = 1'b1;
                        next_state = DIV;
                    end else if (bus.w_op_code_6 == OP_MTHI) begin
                        write_hi = 1'b1;
                    end else if (bus.w_op_code_6 == OP_MTLO) begin
                        write_lo = 1'b1;
                    end
                end
            end
            MUL, DIV: begin
                if (count == CNT_W'(1)) next_state = FIXUP;
            end
            FIXUP: begin
                next_state = IDLE;
                done_next  = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        addend    = acc[0] ? operand : '0;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, operand});
        div_diff  = div_shift - {1'b0, operand};
        product   = res_neg ? -acc : acc;
        quotient  = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remainder = rem_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Multiply keeps the multiplier in the low half of acc; divide shifts the dividend
    // out of the low half while quotient bits shift in behind it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            rem     <= '0;
            operand <= '0;
            count   <= '0;
            div_op  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else if (accept_mul) begin
            acc     <= {{WIDTH{1'b0}}, mag_b};
            operand <= mag_a;
            count   <= CNT_W'(WIDTH);
            div_op  <= 1'b0;
            res_neg <= sign_a ^ sign_b;
            rem_neg <= 1'b0;
        end else if (accept_div) begin
            acc     <= {{WIDTH{1'b0}}, mag_a};
            rem     <= '0;
            operand <= mag_b;
            count   <= CNT_W'(WIDTH);
            div_op  <= 1'b1;
            res_neg <= sign_a ^ sign_b;
            rem_neg <= sign_a;
        end else if (state == MUL) begin
            acc   <= {mul_sum, acc[WIDTH-1:1]};
            count <= count - CNT_W'(1);
        end else if (state == DIV) begin
            rem             <= div_fits ? div_diff : div_shift;
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_fits};
            count           <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi          <= '0;
            lo          <= '0;
            dbz_pending <= 1'b0;
            dbz_value   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= done_next | dbz_pending;
            div_by_zero <= dbz_pending;
            dbz_pending <= accept_dbz;
            if (accept_dbz) dbz_value <= bus.w_input1_x;
            if (dbz_pending) begin
                hi <= dbz_value;
                lo <= '1;
            end else if (state == FIXUP) begin
                if (div_op) begin
                    hi <= remainder;
                    lo <= quotient;
                end else begin
                    {hi, lo} <= product;
                end
            end else begin
                if (write_hi) hi <= bus.w_input1_x;
                if (write_lo) lo <= bus.w_input1_x;
            end
        end
    end

    always_comb begin
        bus.w_output_x = '0;
        if (bus.w_op_code_6 == OP_MFHI)      bus.w_output_x = hi;
        else if (bus.w_op_code_6 == OP_MFLO) bus.w_output_x = lo;
    end

    assign bus.w_busy        = (state != IDLE);
    assign bus.w_done        = done;
    assign bus.w_div_by_zero = div_by_zero;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed checks of mult_div_unit against an arithmetic reference
// model of HI/LO, latency and handshake behaviour.
module tb_mult_div_unit;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 100;

    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    int               checks = 0;
    int               failures = 0;
    logic [WIDTH-1:0] model_hi = '0;
    logic [WIDTH-1:0] model_lo = '0;

    mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference results from plain 64-bit arithmetic; signed division truncates toward zero.
    task automatic modelOp(input logic [5:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           output logic [WIDTH-1:0] hi, output logic [WIDTH-1:0] lo, output logic dbz);
        longint sa, sb, q, r;
        logic [63:0] prod;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        hi  = model_hi;
        lo  = model_lo;
        dbz = 1'b0;
        case (op)
            OP_MULT: begin
                prod = 64'(sa * sb);
                hi = prod[63:32];
                lo = prod[31:0];
            end
            OP_MULTU: begin
                prod = {32'h0, a} * {32'h0, b};
                hi = prod[63:32];
                lo = prod[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    hi  = a;
                    lo  = '1;
                    dbz = 1'b1;
                end else if (op == OP_DIV) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    function automatic logic [WIDTH-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Called just after a falling edge; uses the combinational MFHI/MFLO read path.
    task automatic readHiLo(output logic [WIDTH-1:0] hi, output logic [WIDTH-1:0] lo);
        bus.w_op_code_6 = OP_MFHI;
        #1 hi = bus.w_output_x;
        bus.w_op_code_6 = OP_MFLO;
        #1 lo = bus.w_output_x;
        bus.w_op_code_6 = 6'h00;
        #1;
    endtask

    task automatic checkHiLo(input string tag, input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
        logic [WIDTH-1:0] hi, lo;
        readHiLo(hi, lo);
        checkOutput({tag, "_hi"}, hi, exp_hi);
        checkOutput({tag, "_lo"}, lo, exp_lo);
    endtask

    // Presents a request for one edge, then scrambles the operands to prove they were latched.
    task automatic applyStimulus(input logic [5:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clock);
        bus.w_start     = 1'b1;
        bus.w_op_code_6 = op;
        bus.w_input1_x  = a;
        bus.w_input2_x  = b;
        @(negedge clock);
        bus.w_start     = 1'b0;
        bus.w_op_code_6 = 6'h00;
        bus.w_input1_x  = 32'($urandom);
        bus.w_input2_x  = 32'($urandom);
    endtask

    // done_at counts falling edges after the start edge, the first one being 1.
    task automatic waitDone(output bit seen, output int done_at, output int busy_cycles);
        seen = 1'b0;
        done_at = 0;
        busy_cycles = 0;
        for (int c = 1; c <= TIMEOUT && !seen; c++) begin
            if (bus.w_busy) busy_cycles++;
            if (bus.w_done) begin
                seen = 1'b1;
                done_at = c;
            end else begin
                @(negedge clock);
            end
        end
    endtask

    task automatic runMulDiv(input logic [5:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
        logic [WIDTH-1:0] exp_hi, exp_lo;
        logic             exp_dbz;
        bit               seen;
        int               done_at, busy_cycles;
        modelOp(op, a, b, exp_hi, exp_lo, exp_dbz);
        applyStimulus(op, a, b);
        waitDone(seen, done_at, busy_cycles);
        checkOutput({tag, "_done_seen"}, seen, 1);
        checkOutput({tag, "_latency"}, done_at, exp_dbz ? 2 : WIDTH + 2);
        checkOutput({tag, "_busy_cycles"}, busy_cycles, exp_dbz ? 0 : WIDTH + 1);
        checkOutput({tag, "_dbz"}, bus.w_div_by_zero, exp_dbz);
        checkOutput({tag, "_busy_at_done"}, bus.w_busy, 0);
        checkHiLo(tag, exp_hi, exp_lo);
        model_hi = exp_hi;
        model_lo = exp_lo;
        @(negedge clock);
        checkOutput({tag, "_done_pulse"}, bus.w_done, 0);
        checkOutput({tag, "_dbz_clear"}, bus.w_div_by_zero, 0);
    endtask

    task automatic moveTo(input logic [5:0] op, input logic [WIDTH-1:0] val, input string tag);
        applyStimulus(op, val, 32'($urandom));
        if (op == OP_MTHI) model_hi = val;
        else               model_lo = val;
        checkOutput({tag, "_busy"}, bus.w_busy, 0);
        checkOutput({tag, "_done"}, bus.w_done, 0);
        checkHiLo(tag, model_hi, model_lo);
    endtask

    task automatic ignoredStart(input logic [5:0] op, input string tag);
        applyStimulus(op, 32'($urandom), 32'($urandom));
        checkOutput({tag, "_busy"}, bus.w_busy, 0);
        @(negedge clock);
        checkOutput({tag, "_done"}, bus.w_done, 0);
        checkHiLo(tag, model_hi, model_lo);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] exp_hi, exp_lo, a, b;
        logic             exp_dbz;
        bit               seen;
        int               done_at, busy_cycles, done_count, kind;

        bus.w_start     = 1'b0;
        bus.w_op_code_6 = 6'h00;
        bus.w_input1_x  = '0;
        bus.w_input2_x  = '0;
        repeat (2) @(negedge clock);
        checkOutput("rst_busy", bus.w_busy, 0);
        checkOutput("rst_done", bus.w_done, 0);
        checkOutput("rst_dbz", bus.w_div_by_zero, 0);
        checkHiLo("rst", '0, '0);
        reset = 1'b0;
        @(negedge clock);

        runMulDiv(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        checkOutput("multu_max_hi_const", model_hi, 32'hFFFF_FFFE);
        runMulDiv(OP_MULT, -32'sd3, 32'd7, "mult_neg");
        checkOutput("mult_neg_lo_const", model_lo, 32'hFFFF_FFEB);
        runMulDiv(OP_DIV, -32'sd7, 32'd2, "div_neg");
        runMulDiv(OP_DIVU, 32'd7, 32'd2, "divu_small");
        runMulDiv(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");
        runMulDiv(OP_DIVU, 32'd5, 32'd0, "divu_zero");
        runMulDiv(OP_MULTU, 32'd2, 32'd3, "multu_after_dbz");

        // MT during a busy multiply must be dropped; MFLO returns the pre-operation value.
        moveTo(OP_MTLO, 32'h1234, "mtlo");
        modelOp(OP_MULTU, 32'd2, 32'd3, exp_hi, exp_lo, exp_dbz);
        applyStimulus(OP_MULTU, 32'd2, 32'd3);
        bus.w_op_code_6 = OP_MFLO;
        #1 checkOutput("busy_mflo", bus.w_output_x, 32'h1234);
        bus.w_op_code_6 = 6'h00;
        @(negedge clock);
        bus.w_start     = 1'b1;
        bus.w_op_code_6 = OP_MTHI;
        bus.w_input1_x  = 32'hAAAA;
        @(negedge clock);
        bus.w_start     = 1'b0;
        bus.w_op_code_6 = 6'h00;
        waitDone(seen, done_at, busy_cycles);
        checkOutput("busy_mt_done_seen", seen, 1);
        checkHiLo("busy_mt", exp_hi, exp_lo);
        model_hi = exp_hi;
        model_lo = exp_lo;
        @(negedge clock);

        // Reset part-way through a multiply aborts it without a done pulse.
        applyStimulus(OP_MULT, 32'($urandom), 32'($urandom));
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1 checkOutput("abort_busy_in_reset", bus.w_busy, 0);
        done_count = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_hi = '0;
        model_lo = '0;
        repeat (40) begin
            @(negedge clock);
            if (bus.w_done) done_count++;
        end
        checkOutput("abort_no_done", done_count, 0);
        checkOutput("abort_busy", bus.w_busy, 0);
        checkHiLo("abort", '0, '0);
        runMulDiv(OP_DIVU, 32'd9, 32'd4, "divu_after_abort");

        ignoredStart(6'h00, "ign_op00");
        ignoredStart(OP_MFHI, "ign_mfhi");

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            a = pickOperand();
            b = pickOperand();
            case (kind)
                0, 4:    runMulDiv(OP_MULT, a, b, "rnd_mult");
                1:       runMulDiv(OP_MULTU, a, b, "rnd_multu");
                2, 5:    runMulDiv(OP_DIV, a, b, "rnd_div");
                3:       runMulDiv(OP_DIVU, a, b, "rnd_divu");
                6:       moveTo(OP_MTHI, a, "rnd_mthi");
                7:       moveTo(OP_MTLO, a, "rnd_mtlo");
                default: ignoredStart(6'h1C, "rnd_ign");
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers. It replaces the single-cycle combinational MULT/DIV path in the execute stage. It is parametrised in operand width, runs iterative shift-add multiply and restoring divide with a start/busy/done handshake, and serves MFHI/MFLO/MTHI/MTLO. The execute stage drives it and uses `w_busy` as a stall/interlock source.

## Interface
- `WIDTH`, default 32: operand width; even, ≥ 4. HI and LO are each `WIDTH` bits.
- `clock`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `w_start`, input, 1: request strobe, sampled at a rising edge while idle.
- `w_op_code_6`, input, 6: SPECIAL funct code. MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
- `w_input1_x`, input, `WIDTH`: rs (multiplicand / dividend / MT source).
- `w_input2_x`, input, `WIDTH`: rt (multiplier / divisor).
- `w_output_x`, output, `WIDTH`: HI for MFHI, LO for MFLO, 0 otherwise (combinational from the registers).
- `w_busy`, output, 1: iteration in progress.
- `w_done`, output, 1: one-cycle pulse when HI/LO receive a mult/div result.
- `w_div_by_zero`, output, 1: valid with `w_done`; set when the divide had a zero divisor.

## Operation
- States: IDLE, MUL, DIV, FIXUP.
- IDLE + `w_start` + MULT/MULTU: latch operands, go to MUL.
  - Signed ops use magnitudes and record the result sign (XOR of the operand sign bits).
- IDLE + `w_start` + DIV/DIVU, divisor ≠ 0: latch operands, go to DIV.
  - Quotient sign = XOR of the operand signs.
  - Remainder sign = dividend sign.
- IDLE + `w_start` + DIV/DIVU, divisor = 0: no iteration.
  - Next edge: HI = `w_input1_x`, LO = all ones, `w_done` = 1, `w_div_by_zero` = 1.
  - State stays IDLE.
- MUL: one shift-add step per cycle, `WIDTH` steps, using a 2·`WIDTH` accumulator.
- DIV: one restoring step per cycle, `WIDTH` steps, using a `WIDTH`+1-bit partial remainder. A down-counter of width clog2(`WIDTH`+1) tracks steps.
- FIXUP (all four ops; unsigned ops apply no negation):
  - Apply two's-complement negation per the recorded signs.
  - Write HI:LO. Multiply: HI = upper half, LO = lower half. Divide: HI = remainder, LO = quotient.
  - Pulse `w_done`, return to IDLE.
- Signed corner cases:
  - Magnitude of the most-negative value is 2^(`WIDTH`−1), which is representable unsigned.
  - DIV of most-negative by −1: LO = most-negative (wraps), HI = 0.
- MTHI/MTLO + `w_start` in IDLE: write `w_input1_x` to HI or LO at the edge. No busy, no `w_done`.
- MFHI/MFLO need no `w_start`.
  - `w_output_x` reflects the current HI/LO.
  - While busy it returns pre-operation values; the pipeline stalls on `w_busy`.
- `w_start` while busy: ignored, no queueing; this includes MTHI/MTLO.
- `w_start` with any other opcode: ignored.

## Timing
- Reset values: HI = LO = 0, state IDLE, `w_busy` = 0, `w_done` = 0, `w_div_by_zero` = 0. `w_output_x` = 0 until HI/LO are written.
- Start accepted at edge E0.
- `w_busy` is high after E0 through edge E(`WIDTH`+1).
  - Iteration edges: E1..E`WIDTH`.
  - FIXUP edge: E(`WIDTH`+1). HI/LO update here, `w_busy` falls, `w_done` rises.
- `w_done` is high for exactly the one cycle after E(`WIDTH`+1). Latency is `WIDTH`+1 cycles for every mult/div op and sign.
- `w_div_by_zero` is registered alongside `w_done` and clears with it.
- Divide-by-zero: `w_done` is high the cycle after E1. `w_busy` never asserts.
- A new `w_start` is accepted on the same edge that `w_done` is high (state is IDLE).
- Operands are latched at E0. Input changes after E0 have no effect.
- Reset mid-operation aborts immediately:
  - HI/LO return to 0.
  - No `w_done` is issued, including for a FIXUP in flight.
- MTHI/MTLO written at E0 are visible on `w_output_x` (for MFHI/MFLO) in the cycle after E0.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (`WIDTH`=32) -> HI=0xFFFFFFFE, LO=0x00000001; `w_done` 33 cycles after the start edge; `w_busy` high for 33 cycles.
- MULT −3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MFHI/MFLO read those values on `w_output_x`.
- DIV −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5 / 0 -> `w_done` and `w_div_by_zero` one cycle after start, HI=5, LO=0xFFFFFFFF, `w_busy` never high. The next MULTU 2 × 3 -> `w_div_by_zero`=0, LO=6.
- MTLO 0x1234 -> MFLO reads 0x1234 the next cycle. Start MULTU 2 × 3; MTHI 0xAAAA with `w_start` during busy -> ignored, final HI=0, LO=6. MFLO during busy reads 0x1234.
- Start MULT; assert `reset` 10 cycles later for 2 cycles -> no `w_done` ever; HI=LO=0; `w_busy`=0; a fresh DIVU 9 / 4 completes with LO=2, HI=1.
